led_sprite_reader: RTL and testbench

- Read-side client of the 32x32 RGB565 LED sprite ROMs (on/off images, 1024 x 16, synchronous read, 1-clock data latency).
- Takes pixel coordinates from the VGA timing generator and decides whether each pixel falls inside the sprite.
- Drives the ROM address/enables and muxes the on/off image by LED state; off-sprite and transparent pixels show the background colour.
- Outputs RGB565 plus de/hsync/vsync, all delayed by the same fixed latency, to the VGA output stage.

---
 rtl/sprite_pkg.sv | 16 +
 rtl/sig_delay.sv | 38 +++
 rtl/led_sprite_reader.sv | 154 +++++++++++++++
 tb/tb_led_sprite_reader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants and types for the LED sprite read path.
//   SPR_W, SPR_H     : sprite size in ROM pixels (32 x 32)
//   SPR_ADDR_W       : ROM address width, {row[4:0], col[4:0]}
//   rgb565_t         : one RGB565 pixel word
//   TRANSPARENT_DEF  : default see-through ROM word
package sprite_pkg;

   localparam int SPR_W      = 32;
   localparam int SPR_H      = 32;
   localparam int SPR_ADDR_W = 10;

   typedef logic [15:0] rgb565_t;

   localparam rgb565_t TRANSPARENT_DEF = 16'h0000;

endpackage

// File: rtl/sig_delay.sv
// Reset-clearable shift register, N stages of W bits.
//   clk   : clock
//   reset : synchronous active-high clear of every stage
//   d     : input word
//   q     : d delayed by N clocks
module sig_delay #(
   parameter int N = 3,
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] pipe_q [N];
   logic [W-1:0] pipe_d [N];

   always_comb begin
      pipe_d[0] = d;
      for (int i = 1; i < N; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign q = pipe_q[N-1];

endmodule

// File: rtl/led_sprite_reader.sv
// Read-side client of the 32x32 RGB565 LED sprite ROMs. Decides per pixel
// whether it lies inside the sprite, addresses both ROMs, muxes on/off image
// by the per-frame LED state and substitutes the background colour for
// misses and transparent words. All outputs share a 3-clock latency.
//   clk, reset            : pixel clock, synchronous active-high reset
//   hcount, vcount        : current pixel coordinates
//   de_in/hsync_in/vsync_in : video timing, delayed 3 clocks to *_out
//   frame_start           : once-per-frame pulse latching spr_x/spr_y/led_state
//   led_state             : 1 selects the LED-on image
//   spr_x, spr_y          : sprite top-left corner
//   bg_color              : background RGB565
//   rom_ad/ce/oce/reset   : shared ROM controls
//   rom_on_dout/off_dout  : ROM read data (1-clock latency)
//   rgb, de_out, hsync_out, vsync_out : aligned video out
module led_sprite_reader
   import sprite_pkg::*;
#(
   parameter int      CNT_W       = 10,
   parameter int      SCALE_LOG2  = 0,
   parameter rgb565_t TRANSPARENT = TRANSPARENT_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CNT_W-1:0]      hcount,
   input  logic [CNT_W-1:0]      vcount,
   input  logic                  de_in,
   input  logic                  hsync_in,
   input  logic                  vsync_in,
   input  logic                  frame_start,
   input  logic                  led_state,
   input  logic [CNT_W-1:0]      spr_x,
   input  logic [CNT_W-1:0]      spr_y,
   input  logic [15:0]           bg_color,
   output logic [SPR_ADDR_W-1:0] rom_ad,
   output logic                  rom_ce,
   output logic                  rom_oce,
   output logic                  rom_reset,
   input  logic [15:0]           rom_on_dout,
   input  logic [15:0]           rom_off_dout,
   output logic [15:0]           rgb,
   output logic                  de_out,
   output logic                  hsync_out,
   output logic                  vsync_out
);

   localparam int COORD_W = SPR_ADDR_W / 2;
   localparam logic [CNT_W:0] SPAN_X = (CNT_W+1)'(SPR_W << SCALE_LOG2);
   localparam logic [CNT_W:0] SPAN_Y = (CNT_W+1)'(SPR_H << SCALE_LOG2);

   logic [CNT_W-1:0]      x_l_q, x_l_d, y_l_q, y_l_d;
   logic                  led_l_q, led_l_d;
   logic [CNT_W:0]        dx, dy, dx_sc, dy_sc;
   logic                  hit;
   logic [SPR_ADDR_W-1:0] rom_ad_q, rom_ad_d;
   logic                  rom_ce_q, rom_ce_d;
   logic                  hit1_q, hit1_d, sel1_q, sel1_d;
   logic                  hit2_q, hit2_d, sel2_q, sel2_d;
   rgb565_t               word;
   rgb565_t               rgb_q, rgb_d;
   logic                  de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
   logic [2:0]            sync_mid;

   // Two stages here plus the output register below give the 3-clock alignment;
   // the stage-2 de tap is needed to blank rgb outside active video.
   sig_delay #(.N(2), .W(3)) u_sync_dly (
      .clk   (clk),
      .reset (reset),
      .d     ({vsync_in, hsync_in, de_in}),
      .q     (sync_mid)
   );

   always_comb begin
      x_l_d   = x_l_q;
      y_l_d   = y_l_q;
      led_l_d = led_l_q;
      if (frame_start) begin
         x_l_d   = spr_x;
         y_l_d   = spr_y;
         led_l_d = led_state;
      end

      // One extra bit so a pixel left of / above the sprite reads negative
      // instead of aliasing to a large in-range offset.
      dx    = {1'b0, hcount} - {1'b0, x_l_q};
      dy    = {1'b0, vcount} - {1'b0, y_l_q};
      dx_sc = dx >> SCALE_LOG2;
      dy_sc = dy >> SCALE_LOG2;
      hit   = de_in && !dx[CNT_W] && !dy[CNT_W] && (dx < SPAN_X) && (dy < SPAN_Y);

      rom_ad_d = rom_ad_q;
      if (hit) begin
         rom_ad_d = {dy_sc[COORD_W-1:0], dx_sc[COORD_W-1:0]};
      end
      rom_ce_d = hit;
      hit1_d   = hit;
      sel1_d   = led_l_q;
      hit2_d   = hit1_q;
      sel2_d   = sel1_q;

      word  = sel2_q ? rom_on_dout : rom_off_dout;
      rgb_d = bg_color;
      if (hit2_q && (word != TRANSPARENT)) begin
         rgb_d = word;
      end
      if (!sync_mid[0]) begin
         rgb_d = '0;
      end
      de_d    = sync_mid[0];
      hsync_d = sync_mid[1];
      vsync_d = sync_mid[2];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_l_q    <= '0;
         y_l_q    <= '0;
         led_l_q  <= 1'b0;
         rom_ad_q <= '0;
         rom_ce_q <= 1'b0;
         hit1_q   <= 1'b0;
         sel1_q   <= 1'b0;
         hit2_q   <= 1'b0;
         sel2_q   <= 1'b0;
         rgb_q    <= '0;
         de_q     <= 1'b0;
         hsync_q  <= 1'b0;
         vsync_q  <= 1'b0;
      end else begin
         x_l_q    <= x_l_d;
         y_l_q    <= y_l_d;
         led_l_q  <= led_l_d;
         rom_ad_q <= rom_ad_d;
         rom_ce_q <= rom_ce_d;
         hit1_q   <= hit1_d;
         sel1_q   <= sel1_d;
         hit2_q   <= hit2_d;
         sel2_q   <= sel2_d;
         rgb_q    <= rgb_d;
         de_q     <= de_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
      end
   end

   assign rom_ad    = rom_ad_q;
   assign rom_ce    = rom_ce_q;
   assign rom_oce   = 1'b1;
   assign rom_reset = reset;
   assign rgb       = rgb_q;
   assign de_out    = de_q;
   assign hsync_out = hsync_q;
   assign vsync_out = vsync_q;

endmodule

// File: tb/tb_led_sprite_reader.sv
module tb_led_sprite_reader;

   localparam logic [15:0] BG = 16'h1234;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  hcount, vcount, spr_x, spr_y;
   logic        de_in, hsync_in, vsync_in, frame_start, led_state;
   logic [15:0] bg_color;

   logic [9:0]  rom_ad0, rom_ad1;
   logic        rom_ce0, rom_ce1, rom_oce0, rom_oce1, rom_reset0, rom_reset1;
   logic [15:0] on0, off0, on1, off1, rgb0, rgb1;
   logic        de_out0, hs_out0, vs_out0, de_out1, hs_out1, vs_out1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   led_sprite_reader #(.CNT_W(10), .SCALE_LOG2(0), .TRANSPARENT(16'h0000)) u_dut0 (
      .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .de_in(de_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_start(frame_start),
      .led_state(led_state), .spr_x(spr_x), .spr_y(spr_y), .bg_color(bg_color),
      .rom_ad(rom_ad0), .rom_ce(rom_ce0), .rom_oce(rom_oce0), .rom_reset(rom_reset0),
      .rom_on_dout(on0), .rom_off_dout(off0), .rgb(rgb0), .de_out(de_out0),
      .hsync_out(hs_out0), .vsync_out(vs_out0));

   led_sprite_reader #(.CNT_W(10), .SCALE_LOG2(1), .TRANSPARENT(16'h0000)) u_dut1 (
      .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .de_in(de_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_start(frame_start),
      .led_state(led_state), .spr_x(spr_x), .spr_y(spr_y), .bg_color(bg_color),
      .rom_ad(rom_ad1), .rom_ce(rom_ce1), .rom_oce(rom_oce1), .rom_reset(rom_reset1),
      .rom_on_dout(on1), .rom_off_dout(off1), .rgb(rgb1), .de_out(de_out1),
      .hsync_out(hs_out1), .vsync_out(vs_out1));

   // ROM images: one transparent word at row 1 / col 1, otherwise
   // address-dependent and distinct between the two images.
   function automatic logic [15:0] on_fn(input logic [9:0] a);
      return (a == 10'h021) ? 16'h0000 : (16'hF966 ^ {6'd0, a});
   endfunction
   function automatic logic [15:0] off_fn(input logic [9:0] a);
      return (a == 10'h021) ? 16'h0000 : (16'h0555 ^ {6'd0, a});
   endfunction

   always @(posedge clk) begin
      if (rom_ce0) begin
         on0  <= on_fn(rom_ad0);
         off0 <= off_fn(rom_ad0);
      end
      if (rom_ce1) begin
         on1  <= on_fn(rom_ad1);
         off1 <= off_fn(rom_ad1);
      end
   end

   typedef struct {
      logic [15:0] rgb0;
      logic [15:0] rgb1;
      logic        de;
      logic        hs;
      logic        vs;
   } exp_t;

   typedef struct {
      logic [9:0] h;
      logic [9:0] v;
      logic       de;
      logic       fs;
      logic       led;
      logic       hit0;
      logic [9:0] ad0;
      logic       hit1;
      logic [9:0] ad1;
   } vec_t;

   exp_t       sbq[$];
   vec_t       tab[10];
   vec_t       nov;
   logic [9:0] lx = '0, ly = '0;
   logic       lled = 1'b0;
   logic [9:0] prev_ad0 = '0, prev_ad1 = '0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic void model(input int s, input logic [9:0] h, input logic [9:0] v,
                                 input logic de, output logic hit, output logic [9:0] ad);
      int dx, dy, span;
      dx   = int'(h) - int'(lx);
      dy   = int'(v) - int'(ly);
      span = 32 << s;
      hit  = de && (dx >= 0) && (dy >= 0) && (dx < span) && (dy < span);
      ad   = 10'((((dy >> s) & 31) * 32) + ((dx >> s) & 31));
   endfunction

   function automatic logic [15:0] pix(input logic de, input logic hit, input logic [9:0] ad);
      logic [15:0] w;
      w = lled ? on_fn(ad) : off_fn(ad);
      if (!de) return 16'h0000;
      return (hit && w != 16'h0000) ? w : BG;
   endfunction

   // Called at a negedge: check the output due now, drive one pixel, then
   // check the ROM controls one clock later.
   task automatic cyc(input logic rst, input logic fs, input logic led, input logic de,
                      input logic hs, input logic vs, input logic [9:0] h, input logic [9:0] v,
                      input logic [9:0] sx, input logic [9:0] sy,
                      input logic use_tab, input vec_t tv);
      exp_t       e, z;
      logic       h0, h1;
      logic [9:0] a0, a1, ea0, ea1;
      logic       eh0, eh1;
      if (sbq.size() == 3) begin
         e = sbq.pop_front();
         chk("rgb_s0", rgb0, e.rgb0);
         chk("rgb_s1", rgb1, e.rgb1);
         chk("de_out", 16'(de_out0), 16'(e.de));
         chk("hsync_out", 16'(hs_out0), 16'(e.hs));
         chk("vsync_out", 16'(vs_out1), 16'(e.vs));
         chk("de_out_s1", 16'(de_out1), 16'(e.de));
      end
      reset = rst; frame_start = fs; led_state = led; de_in = de;
      hsync_in = hs; vsync_in = vs; hcount = h; vcount = v; spr_x = sx; spr_y = sy;
      #1;
      chk("rom_reset", 16'(rom_reset0), 16'(rst));
      chk("rom_oce", 16'(rom_oce1), 16'h0001);

      model(0, h, v, de, h0, a0);
      model(1, h, v, de, h1, a1);
      z.rgb0 = '0; z.rgb1 = '0; z.de = 1'b0; z.hs = 1'b0; z.vs = 1'b0;
      if (rst) begin
         foreach (sbq[i]) sbq[i] = z;
         e = z;
      end else begin
         e.rgb0 = pix(de, h0, a0);
         e.rgb1 = pix(de, h1, a1);
         e.de = de; e.hs = hs; e.vs = vs;
      end
      sbq.push_back(e);

      eh0 = !rst && h0;
      eh1 = !rst && h1;
      ea0 = rst ? 10'd0 : (h0 ? a0 : prev_ad0);
      ea1 = rst ? 10'd0 : (h1 ? a1 : prev_ad1);
      prev_ad0 = ea0;
      prev_ad1 = ea1;
      if (use_tab) begin
         eh0 = tv.hit0; ea0 = tv.ad0;
         eh1 = tv.hit1; ea1 = tv.ad1;
      end
      if (rst) begin
         lx = '0; ly = '0; lled = 1'b0;
      end else if (fs) begin
         lx = sx; ly = sy; lled = led;
      end

      @(posedge clk);
      @(negedge clk);
      chk("rom_ce_s0", 16'(rom_ce0), 16'(eh0));
      chk("rom_ad_s0", 16'(rom_ad0), 16'(ea0));
      chk("rom_ce_s1", 16'(rom_ce1), 16'(eh1));
      chk("rom_ad_s1", 16'(rom_ad1), 16'(ea1));
   endtask

   initial begin
      logic       r_hs, r_vs, r_de, r_fs, r_led;
      logic [9:0] r_h, r_v, r_sx, r_sy;

      nov = '{h:10'd0, v:10'd0, de:1'b0, fs:1'b0, led:1'b0, hit0:1'b0, ad0:10'd0, hit1:1'b0, ad1:10'd0};
      tab[0] = '{h:10'd0,   v:10'd0,   de:1'b0, fs:1'b1, led:1'b1, hit0:1'b0, ad0:10'h000, hit1:1'b0, ad1:10'h000};
      tab[1] = '{h:10'd310, v:10'd230, de:1'b1, fs:1'b0, led:1'b1, hit0:1'b1, ad0:10'h0C6, hit1:1'b1, ad1:10'd99};
      tab[2] = '{h:10'd368, v:10'd230, de:1'b1, fs:1'b0, led:1'b1, hit0:1'b0, ad0:10'h0C6, hit1:1'b0, ad1:10'd99};
      tab[3] = '{h:10'd303, v:10'd224, de:1'b1, fs:1'b0, led:1'b1, hit0:1'b0, ad0:10'h0C6, hit1:1'b0, ad1:10'd99};
      tab[4] = '{h:10'd335, v:10'd255, de:1'b1, fs:1'b0, led:1'b1, hit0:1'b1, ad0:10'h3FF, hit1:1'b1, ad1:10'h1EF};
      tab[5] = '{h:10'd336, v:10'd255, de:1'b1, fs:1'b0, led:1'b1, hit0:1'b0, ad0:10'h3FF, hit1:1'b1, ad1:10'h1F0};
      tab[6] = '{h:10'd305, v:10'd225, de:1'b1, fs:1'b0, led:1'b1, hit0:1'b1, ad0:10'h021, hit1:1'b1, ad1:10'h000};
      tab[7] = '{h:10'd310, v:10'd230, de:1'b0, fs:1'b0, led:1'b1, hit0:1'b0, ad0:10'h021, hit1:1'b0, ad1:10'h000};
      tab[8] = '{h:10'd400, v:10'd100, de:1'b1, fs:1'b0, led:1'b1, hit0:1'b0, ad0:10'h021, hit1:1'b0, ad1:10'h000};
      tab[9] = '{h:10'd320, v:10'd240, de:1'b1, fs:1'b0, led:1'b1, hit0:1'b1, ad0:10'h210, hit1:1'b1, ad1:10'h108};

      reset = 1'b1; frame_start = 1'b0; led_state = 1'b0; de_in = 1'b0;
      hsync_in = 1'b0; vsync_in = 1'b0; hcount = '0; vcount = '0;
      spr_x = '0; spr_y = '0; bg_color = BG;
      @(negedge clk);
      cyc(1, 0, 0, 0, 0, 0, 10'd0, 10'd0, 10'd0, 10'd0, 0, nov);
      cyc(1, 0, 0, 0, 0, 0, 10'd0, 10'd0, 10'd0, 10'd0, 0, nov);

      // Address, scaling, transparency and edge vectors.
      for (int i = 0; i < 10; i++) begin
         r_hs = 1'($urandom_range(1)); r_vs = 1'($urandom_range(1));
         cyc(0, tab[i].fs, tab[i].led, tab[i].de, r_hs, r_vs, tab[i].h, tab[i].v,
             10'd304, 10'd224, 1, tab[i]);
      end

      // LED state only takes effect at frame_start, and not for the pixel in that cycle.
      cyc(0, 0, 0, 1, 0, 0, 10'd310, 10'd230, 10'd304, 10'd224, 0, nov);
      cyc(0, 1, 0, 1, 0, 0, 10'd311, 10'd230, 10'd304, 10'd224, 0, nov);
      cyc(0, 0, 0, 1, 0, 0, 10'd312, 10'd230, 10'd304, 10'd224, 0, nov);
      cyc(0, 0, 1, 1, 0, 0, 10'd313, 10'd230, 10'd304, 10'd224, 0, nov);
      cyc(0, 1, 1, 0, 0, 0, 10'd0, 10'd0, 10'd304, 10'd224, 0, nov);

      // Random timing and pixels around the sprite, occasional frame_start.
      for (int i = 0; i < 300; i++) begin
         r_hs  = 1'($urandom_range(1));
         r_vs  = 1'($urandom_range(1));
         r_de  = 1'($urandom_range(1));
         r_fs  = ($urandom_range(15) == 0);
         r_led = 1'($urandom_range(1));
         r_h   = 10'($urandom_range(360, 280));
         r_v   = 10'($urandom_range(270, 200));
         r_sx  = 10'($urandom_range(312, 296));
         r_sy  = 10'($urandom_range(232, 216));
         cyc(0, r_fs, r_led, r_de, r_hs, r_vs, r_h, r_v, r_sx, r_sy, 0, nov);
      end

      // Reset in the middle of a sprite line.
      cyc(0, 1, 1, 0, 0, 0, 10'd0, 10'd0, 10'd304, 10'd224, 0, nov);
      cyc(0, 0, 1, 1, 1, 0, 10'd310, 10'd230, 10'd304, 10'd224, 0, nov);
      cyc(1, 0, 1, 1, 1, 1, 10'd311, 10'd230, 10'd304, 10'd224, 0, nov);
      cyc(0, 0, 1, 1, 0, 1, 10'd5, 10'd5, 10'd304, 10'd224, 0, nov);
      cyc(0, 0, 1, 1, 1, 0, 10'd6, 10'd5, 10'd304, 10'd224, 0, nov);
      cyc(0, 0, 1, 1, 0, 0, 10'd31, 10'd31, 10'd304, 10'd224, 0, nov);
      cyc(0, 0, 1, 1, 0, 0, 10'd32, 10'd5, 10'd304, 10'd224, 0, nov);
      cyc(0, 0, 1, 1, 0, 0, 10'd1, 10'd1, 10'd304, 10'd224, 0, nov);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 0, 0, 10'd0, 10'd0, 10'd304, 10'd224, 0, nov);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
